pll_lock_ctrl: RTL and testbench

- Refclk-domain supervisor that sequences the DCO PLL: holds the loop in reset, releases it, qualifies lock from the sampled phase error, issues timed brake pulses, and retries or fails on acquisition timeout.
- Sits beside the PLL and drives its loop reset and brake inputs.
- Consumes the per-refclk signed phase error (target phase minus DCO phase) that the loop filter already computes.

---
 rtl/pll_lock_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
// PLL lock supervisor: sequences loop reset, qualifies lock from the sampled
// phase error, times brake pulses and retries or fails on acquisition timeout.
module pll_lock_ctrl #(
  parameter int unsigned ERR_W         = 16,
  parameter int unsigned LOCK_TOL      = 8,
  parameter int unsigned UNLOCK_TOL    = 32,
  parameter int unsigned LOCK_CNT      = 16,
  parameter int unsigned UNLOCK_CNT    = 4,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned ACQ_TIMEOUT   = 1024,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned BRAKE_CYCLES  = 100,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic             refclk,
  input  logic             resetn,
  input  logic             enable,
  input  logic [ERR_W-1:0] phase_err,
  input  logic             err_valid,
  input  logic             brake_req,
  output logic             pll_resetn,
  output logic             brake,
  output logic             locked,
  output logic             fail,
  output logic [2:0]       state,
  output logic [1:0]       retry_cnt
);

  typedef enum logic [2:0] {
    StOff     = 3'd0,
    StReset   = 3'd1,
    StAcquire = 3'd2,
    StLocked  = 3'd3,
    StBrake   = 3'd4,
    StRecover = 3'd5,
    StFail    = 3'd6
  } state_e;

  localparam int unsigned MaxAb  = (ACQ_TIMEOUT > BRAKE_CYCLES) ? ACQ_TIMEOUT : BRAKE_CYCLES;
  localparam int unsigned MaxCd  = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MaxCnt = (MaxAb > MaxCd) ? MaxAb : MaxCd;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam int unsigned GoodW  = $clog2(LOCK_CNT + 1);
  localparam int unsigned BadW   = $clog2(UNLOCK_CNT + 1);

  localparam logic [CntW-1:0]  RstLd    = CntW'(RST_CYCLES);
  localparam logic [CntW-1:0]  BrakeLd  = CntW'(BRAKE_CYCLES);
  localparam logic [CntW-1:0]  SettleLd = CntW'(SETTLE_CYCLES);
  localparam logic [CntW-1:0]  TmoLast  = CntW'(ACQ_TIMEOUT - 1);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);
  localparam logic [GoodW-1:0] GoodLast = GoodW'(LOCK_CNT - 1);
  localparam logic [BadW-1:0]  BadLast  = BadW'(UNLOCK_CNT - 1);
  localparam logic [ERR_W:0]   LockTol  = (ERR_W+1)'(LOCK_TOL);
  localparam logic [ERR_W:0]   UnlkTol  = (ERR_W+1)'(UNLOCK_TOL);

  state_e           r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [GoodW-1:0] r_good, w_good_d;
  logic [BadW-1:0]  r_bad, w_bad_d;
  logic [1:0]       r_retry, w_retry_d;
  logic             r_pll_resetn, r_brake, r_locked, r_fail;

  // One extra bit so the most negative error maps to a positive magnitude.
  logic [ERR_W:0] w_err_ext;
  logic [ERR_W:0] w_err_mag;
  logic           w_good_smp;
  logic           w_bad_smp;

  assign w_err_ext  = {phase_err[ERR_W-1], phase_err};
  assign w_err_mag  = w_err_ext[ERR_W] ? (~w_err_ext + 1'b1) : w_err_ext;
  assign w_good_smp = (w_err_mag <= LockTol);
  assign w_bad_smp  = (w_err_mag > UnlkTol);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_good_d  = r_good;
    w_bad_d   = r_bad;
    w_retry_d = r_retry;
    if (!enable) begin
      w_state_d = StOff;
      w_cnt_d   = '0;
      w_good_d  = '0;
      w_bad_d   = '0;
      w_retry_d = '0;
    end else begin
      case (r_state)
        StOff: begin
          w_state_d = StReset;
          w_cnt_d   = RstLd;
        end
        StReset: begin
          if (r_cnt <= CntOne) begin
            w_state_d = StAcquire;
            w_cnt_d   = '0;
            w_good_d  = '0;
          end else begin
            w_cnt_d = r_cnt - 1'b1;
          end
        end
        StAcquire: begin
          if (err_valid) begin
            w_good_d = w_good_smp ? r_good + 1'b1 : '0;
          end
          // Lock is checked before timeout so a tie resolves to LOCKED.
          if (err_valid && w_good_smp && (r_good == GoodLast)) begin
            w_state_d = StLocked;
            w_good_d  = '0;
            w_bad_d   = '0;
            w_retry_d = '0;
          end else if (r_cnt == TmoLast) begin
            if (32'(r_retry) < MAX_RETRY) begin
              w_state_d = StReset;
              w_cnt_d   = RstLd;
              w_retry_d = r_retry + 2'd1;
            end else begin
              w_state_d = StFail;
              w_cnt_d   = '0;
            end
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        StLocked: begin
          if (brake_req) begin
            w_state_d = StBrake;
            w_cnt_d   = BrakeLd;
            w_bad_d   = '0;
          end else if (err_valid) begin
            if (w_bad_smp) begin
              if (r_bad == BadLast) begin
                w_state_d = StAcquire;
                w_cnt_d   = '0;
                w_good_d  = '0;
                w_bad_d   = '0;
              end else begin
                w_bad_d = r_bad + 1'b1;
              end
            end else begin
              w_bad_d = '0;
            end
          end
        end
        StBrake: begin
          if (r_cnt <= CntOne) begin
            w_state_d = StRecover;
            w_cnt_d   = SettleLd;
          end else begin
            w_cnt_d = r_cnt - 1'b1;
          end
        end
        StRecover: begin
          if (r_cnt <= CntOne) begin
            w_state_d = StAcquire;
            w_cnt_d   = '0;
            w_good_d  = '0;
          end else begin
            w_cnt_d = r_cnt - 1'b1;
          end
        end
        StFail: begin
          w_state_d = StFail;
        end
        default: begin
          w_state_d = StOff;
          w_cnt_d   = '0;
          w_good_d  = '0;
          w_bad_d   = '0;
          w_retry_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move with `state`.
  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= StOff;
      r_cnt        <= '0;
      r_good       <= '0;
      r_bad        <= '0;
      r_retry      <= '0;
      r_pll_resetn <= 1'b0;
      r_brake      <= 1'b0;
      r_locked     <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_good       <= w_good_d;
      r_bad        <= w_bad_d;
      r_retry      <= w_retry_d;
      r_pll_resetn <= (w_state_d inside {StAcquire, StLocked, StBrake, StRecover});
      r_brake      <= (w_state_d == StBrake);
      r_locked     <= (w_state_d == StLocked);
      r_fail       <= (w_state_d == StFail);
    end
  end

  assign pll_resetn = r_pll_resetn;
  assign brake      = r_brake;
  assign locked     = r_locked;
  assign fail       = r_fail;
  assign state      = r_state;
  assign retry_cnt  = r_retry;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl: lock/unlock, brake timing, retry/fail,
// enable abort, async reset and the lock-vs-timeout tie.
module tb_pll_lock_ctrl;

  localparam logic [2:0] StOff     = 3'd0;
  localparam logic [2:0] StReset   = 3'd1;
  localparam logic [2:0] StAcquire = 3'd2;
  localparam logic [2:0] StLocked  = 3'd3;
  localparam logic [2:0] StBrake   = 3'd4;
  localparam logic [2:0] StRecover = 3'd5;
  localparam logic [2:0] StFail    = 3'd6;

  logic        refclk;
  logic        resetn;
  logic        enable;
  logic [15:0] phase_err;
  logic        err_valid;
  logic        brake_req;
  logic        pll_resetn;
  logic        brake;
  logic        locked;
  logic        fail;
  logic [2:0]  state;
  logic [1:0]  retry_cnt;

  logic [8:0]  obs;
  logic [8:0]  want;
  int          n_vec;
  int          n_bad;

  assign obs = {state, pll_resetn, brake, locked, fail, retry_cnt};

  pll_lock_ctrl dut (
    .refclk     (refclk),
    .resetn     (resetn),
    .enable     (enable),
    .phase_err  (phase_err),
    .err_valid  (err_valid),
    .brake_req  (brake_req),
    .pll_resetn (pll_resetn),
    .brake      (brake),
    .locked     (locked),
    .fail       (fail),
    .state      (state),
    .retry_cnt  (retry_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Packs expected {state, pll_resetn, brake, locked, fail, retry_cnt}.
  function automatic logic [8:0] exp_o(input logic [2:0] st, input logic prn, input logic brk,
                                       input logic lck, input logic fl, input logic [1:0] rty);
    return {st, prn, brk, lck, fl, rty};
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; phase_err = '0; err_valid = 1'b0; brake_req = 1'b0;
    repeat (3) tick();
    want = exp_o(StOff, 0, 0, 0, 0, 0); n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL reset got=%b want=%b", obs, want); end
    resetn = 1'b1;
    tick();
    n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL off_idle got=%b want=%b", obs, want); end
  endtask

  task automatic test_acquire();
    enable = 1'b1; err_valid = 1'b1; phase_err = 16'd3;
    for (int k = 1; k <= 4; k++) begin
      tick();
      want = exp_o(StReset, 0, 0, 0, 0, 0); n_vec++;
      if (obs !== want) begin n_bad++; $display("FAIL rst_hold k=%0d got=%b want=%b", k, obs, want); end
    end
    tick();
    want = exp_o(StAcquire, 1, 0, 0, 0, 0); n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL acq_entry got=%b want=%b", obs, want); end
    for (int k = 1; k <= 15; k++) begin
      tick();
      n_vec++;
      if (obs !== want) begin n_bad++; $display("FAIL acq_count k=%0d got=%b want=%b", k, obs, want); end
    end
    tick();
    want = exp_o(StLocked, 1, 0, 1, 0, 0); n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL lock16 got=%b want=%b", obs, want); end
  endtask

  task automatic test_unlock();
    logic [15:0] seq [8];
    seq = '{16'd40, 16'd40, 16'd40, 16'd5, 16'd40, 16'd40, 16'd40, 16'd40};
    err_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      phase_err = seq[i];
      tick();
      want = (i < 7) ? exp_o(StLocked, 1, 0, 1, 0, 0) : exp_o(StAcquire, 1, 0, 0, 0, 0);
      n_vec++;
      if (obs !== want) begin n_bad++; $display("FAIL unlock i=%0d got=%b want=%b", i, obs, want); end
    end
    phase_err = 16'd3;
    repeat (16) tick();
    want = exp_o(StLocked, 1, 0, 1, 0, 0); n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL relock got=%b want=%b", obs, want); end
    // 20 is inside the hysteresis band, so it must clear the bad count too.
    seq = '{16'd40, 16'd40, 16'd40, 16'd20, 16'd40, 16'd40, 16'd40, 16'd40};
    for (int i = 0; i < 8; i++) begin
      phase_err = seq[i];
      tick();
      want = (i < 7) ? exp_o(StLocked, 1, 0, 1, 0, 0) : exp_o(StAcquire, 1, 0, 0, 0, 0);
      n_vec++;
      if (obs !== want) begin n_bad++; $display("FAIL inband i=%0d got=%b want=%b", i, obs, want); end
    end
    phase_err = 16'd3;
    repeat (16) tick();
    want = exp_o(StLocked, 1, 0, 1, 0, 0); n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL relock2 got=%b want=%b", obs, want); end
  endtask

  task automatic test_brake();
    brake_req = 1'b1; phase_err = 16'd3;
    tick();
    want = exp_o(StBrake, 1, 1, 0, 0, 0); n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL brake_entry got=%b want=%b", obs, want); end
    phase_err = 16'd500;
    for (int k = 2; k <= 100; k++) begin
      if (k == 11) brake_req = 1'b0;
      tick();
      n_vec++;
      if (obs !== want) begin n_bad++; $display("FAIL brake_hold k=%0d got=%b want=%b", k, obs, want); end
    end
    want = exp_o(StRecover, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_vec++;
      if (obs !== want) begin n_bad++; $display("FAIL recover k=%0d got=%b want=%b", k, obs, want); end
    end
    tick();
    want = exp_o(StAcquire, 1, 0, 0, 0, 0); n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL post_recover got=%b want=%b", obs, want); end
    phase_err = 16'd3;
    repeat (15) tick();
    n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL brake_acq15 got=%b want=%b", obs, want); end
    tick();
    want = exp_o(StLocked, 1, 0, 1, 0, 0); n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL brake_relock got=%b want=%b", obs, want); end
  endtask

  task automatic test_retry_fail();
    enable = 1'b0;
    tick();
    want = exp_o(StOff, 0, 0, 0, 0, 0); n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL disable got=%b want=%b", obs, want); end
    enable = 1'b1; phase_err = 16'd100; err_valid = 1'b1;
    tick();
    for (int r = 0; r < 4; r++) begin
      repeat (3) tick();
      want = exp_o(StReset, 0, 0, 0, 0, 2'(r)); n_vec++;
      if (obs !== want) begin n_bad++; $display("FAIL retry_rst r=%0d got=%b want=%b", r, obs, want); end
      tick();
      want = exp_o(StAcquire, 1, 0, 0, 0, 2'(r)); n_vec++;
      if (obs !== want) begin n_bad++; $display("FAIL retry_acq r=%0d got=%b want=%b", r, obs, want); end
      repeat (1023) tick();
      n_vec++;
      if (obs !== want) begin n_bad++; $display("FAIL retry_last r=%0d got=%b want=%b", r, obs, want); end
      tick();
      want = (r < 3) ? exp_o(StReset, 0, 0, 0, 0, 2'(r + 1)) : exp_o(StFail, 0, 0, 0, 1, 2'd3);
      n_vec++;
      if (obs !== want) begin n_bad++; $display("FAIL retry_tmo r=%0d got=%b want=%b", r, obs, want); end
    end
    repeat (20) tick();
    n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL fail_sticky got=%b want=%b", obs, want); end
    enable = 1'b0;
    tick();
    want = exp_o(StOff, 0, 0, 0, 0, 0); n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL fail_clear got=%b want=%b", obs, want); end
  endtask

  task automatic test_abort();
    enable = 1'b1; phase_err = 16'd3; err_valid = 1'b1;
    repeat (21) tick();
    want = exp_o(StLocked, 1, 0, 1, 0, 0); n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL abort_lock got=%b want=%b", obs, want); end
    brake_req = 1'b1;
    tick();
    brake_req = 1'b0;
    repeat (49) tick();
    want = exp_o(StBrake, 1, 1, 0, 0, 0); n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL brake50 got=%b want=%b", obs, want); end
    enable = 1'b0;
    tick();
    want = exp_o(StOff, 0, 0, 0, 0, 0); n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL brake_abort got=%b want=%b", obs, want); end
    enable = 1'b1; phase_err = 16'd100;
    repeat (5) tick();
    repeat (1024) tick();
    repeat (14) tick();
    want = exp_o(StAcquire, 1, 0, 0, 0, 2'd1); n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL pre_async got=%b want=%b", obs, want); end
    #2;
    resetn = 1'b0;
    #1;
    want = exp_o(StOff, 0, 0, 0, 0, 0); n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL async_reset got=%b want=%b", obs, want); end
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_tie();
    enable = 1'b0;
    tick();
    enable = 1'b1; phase_err = 16'd100; err_valid = 1'b1;
    repeat (1 + 4 + 1024 + 4) tick();
    want = exp_o(StAcquire, 1, 0, 0, 0, 2'd1); n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL tie_acq got=%b want=%b", obs, want); end
    repeat (1008) tick();
    phase_err = 16'hFFF8;
    repeat (15) tick();
    n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL tie_pre got=%b want=%b", obs, want); end
    tick();
    want = exp_o(StLocked, 1, 0, 1, 0, 0); n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL tie_lock got=%b want=%b", obs, want); end
    phase_err = 16'hFFE0;
    repeat (6) tick();
    n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL tol32 got=%b want=%b", obs, want); end
    phase_err = 16'h8000;
    repeat (3) tick();
    n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL min_neg3 got=%b want=%b", obs, want); end
    tick();
    want = exp_o(StAcquire, 1, 0, 0, 0, 0); n_vec++;
    if (obs !== want) begin n_bad++; $display("FAIL min_neg4 got=%b want=%b", obs, want); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_acquire();
    test_unlock();
    test_brake();
    test_retry_fail();
    test_abort();
    test_tie();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
